mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the address-generate/execute stage.
- Consumes the execute latch (ALU result/effective address, store data, destination register, memory op) and performs the data-memory access over a req/ack handshake.
- Produces the MEM latch consumed by writeback, plus a stall back to execute and a forwarding bundle.
- Multi-cycle memory is supported: an FSM holds the request and stalls upstream until ack or timeout.

Parameters:
- DBITS, 32, data/address width.
- REGNOBITS, 5, register-number width.
- ACK_TIMEOUT, 16, max cycles waiting for dmem_ack before an error completion; must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute latch holds a real instruction
- in_memop  in  4  memory op code (package constants)
- in_result  in  DBITS  ALU result / effective address
- in_sdata  in  DBITS  store data (rs2)
- in_rd  in  REGNOBITS  destination register
- in_wr_reg  in  1  instruction writes rd
- in_pc  in  DBITS  instruction PC, carried for debug
- stall_to_agex  out  1  execute must hold its latch
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write request
- dmem_addr  out  DBITS  word-aligned address ({addr[DBITS-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  DBITS  lane-replicated store data
- dmem_rdata  in  DBITS  read data, valid with dmem_ack
- dmem_ack  in  1  completes the current request
- mem_valid  out  1  MEM latch valid
- mem_rd  out  REGNOBITS  latched rd
- mem_wr_reg  out  1  latched register-write enable
- mem_result  out  DBITS  load data or passed-through ALU result
- mem_pc  out  DBITS  latched PC
- mem_err  out  1  access timed out (or misaligned, if enabled)
- fwd_valid  out  1  equals mem_valid & mem_wr_reg
- fwd_rd  out  REGNOBITS  equals mem_rd
- fwd_data  out  DBITS  equals mem_result

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - All registered outputs 0: mem_valid, mem_wr_reg, mem_rd, mem_result, mem_pc, mem_err, dmem_req, dmem_we.
  - stall_to_agex=0.
- Memory ops: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=9, SH=10, SW=11. Any other code is treated as NONE.
- IDLE, in_valid and op NONE:
  - MEM latch loads at the next edge: mem_valid=1, mem_result=in_result.
  - Latency 1, no stall.
- IDLE, in_valid and memory op:
  - Next edge: dmem_req=1, dmem_addr/be/we/wdata registered, state=BUSY, mem_valid=0.
- BUSY:
  - stall_to_agex = ~dmem_ack (combinational). The execute inputs are stable while stalled.
  - The request holds steady; the counter increments each cycle.
  - On dmem_ack, at the next edge: dmem_req=0, state=IDLE, MEM latch written.
    - Loads: mem_result = extracted, extended data.
    - Stores: mem_wr_reg=0.
  - If the counter reaches ACK_TIMEOUT-1 without ack: drop dmem_req, write the MEM latch with mem_err=1, mem_wr_reg=0, mem_result=0, then IDLE. stall_to_agex deasserts in that final BUSY cycle.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Back-to-back: the cycle after ack, IDLE accepts the next in_valid. Minimum memory-op throughput is 1 per 2 cycles with a zero-wait ack.
- in_valid=0 in IDLE: mem_valid=0 next edge; other latch fields hold.
- Byte enables (o = addr[1:0]):
  - Byte ops: 1<<o.
  - Half ops: 3<<(o[1]*2).
  - Word ops: 4'hF.
- Store data lanes:
  - SB: sdata[7:0] replicated ×4.
  - SH: sdata[15:0] replicated ×2.
  - SW: unchanged.
- Load extract: shift dmem_rdata right by o×8 (half ops use o[1]×16); sign-extend for LB/LH, zero-extend for LBU/LHU.
- Misaligned (half with o[0]=1, word with o≠0), without the feature: the low address bits are ignored per the lane rules above.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no dmem_req.
  - The MEM latch is written next cycle with mem_err=1, mem_wr_reg=0, mem_result=in_result (faulting address).
- Not defined: no check; the ignore-low-bits behaviour above applies.

Decomposition:
- Package mem_pkg: memop codes, state enum {IDLE, BUSY}, helper constants for lane widths.
- One sub-module, mem_align: purely combinational generation of byte enables, store lanes and load extract/extend.
- FSM, counter and latch stay in mem_stage.

Test Plan:
- ALU passthrough: in_valid=1, NONE, in_result=0x1234, rd=5, wr=1 → next cycle mem_valid=1, mem_result=0x1234, fwd_rd=5, no stall.
- LB with zero-wait ack: addr=0x1003, rdata=0x80FF_FF00 → dmem_be=4'b1000, dmem_addr=0x1000; after ack mem_result=0xFFFF_FF80.
- SH, 3-cycle ack latency: addr=0x2002, sdata=0xABCD → dmem_be=4'b1100, wdata=0xABCD_ABCD, stall_to_agex high for 3 cycles, mem_wr_reg=0.
- Timeout: ACK_TIMEOUT=16, no ack → dmem_req drops after 16 BUSY cycles, mem_valid=1, mem_err=1.
- Async reset asserted mid-BUSY → dmem_req, stall_to_agex and mem_valid are 0 immediately; state IDLE after release.
- With MEM_MISALIGN_TRAP_EN: LW at 0x3001 → no dmem_req, next cycle mem_err=1, mem_result=0x3001.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: op codes, FSM states,
// lane constants and op classification helpers.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd9;
  localparam logic [3:0] OP_SH   = 4'd10;
  localparam logic [3:0] OP_SW   = 4'd11;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;
  localparam int LANES     = 4;

  // Unlisted codes classify as SZ_NONE, so they behave exactly like OP_NONE.
  function automatic size_e op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      OP_LW, OP_SW:         op_size = SZ_WORD;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    is_mem = (op_size(op) != SZ_NONE);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for data memory: byte enables, store-data
// replication, load extraction with sign/zero extension, misalignment flag.
module mem_align
  import mem_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [3:0]       op,
  input  logic [1:0]       offset,
  input  logic [DBITS-1:0] sdata,
  input  logic [DBITS-1:0] rdata,
  output logic [3:0]       be,
  output logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] ldata,
  output logic             misaligned
);

  size_e            sz;
  logic [DBITS-1:0] shifted;

  always_comb begin
    sz         = op_size(op);
    be         = 4'b0000;
    wdata      = sdata;
    shifted    = rdata;
    ldata      = rdata;
    misaligned = 1'b0;
    case (sz)
      SZ_BYTE: begin
        be      = 4'b0001 << offset;
        wdata   = {(DBITS/BYTE_BITS){sdata[BYTE_BITS-1:0]}};
        shifted = rdata >> {offset, 3'b000};
        if (op == OP_LB)
          ldata = {{(DBITS-BYTE_BITS){shifted[BYTE_BITS-1]}}, shifted[BYTE_BITS-1:0]};
        else
          ldata = {{(DBITS-BYTE_BITS){1'b0}}, shifted[BYTE_BITS-1:0]};
      end
      SZ_HALF: begin
        // offset[0] is dropped: an odd half access lands on its containing half.
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata      = {(DBITS/HALF_BITS){sdata[HALF_BITS-1:0]}};
        shifted    = rdata >> {offset[1], 4'b0000};
        misaligned = offset[0];
        if (op == OP_LH)
          ldata = {{(DBITS-HALF_BITS){shifted[HALF_BITS-1]}}, shifted[HALF_BITS-1:0]};
        else
          ldata = {{(DBITS-HALF_BITS){1'b0}}, shifted[HALF_BITS-1:0]};
      end
      SZ_WORD: begin
        be         = 4'hF;
        misaligned = (offset != 2'b00);
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses over req/ack, stalls execute
// while waiting, and writes the MEM latch. Define MEM_MISALIGN_TRAP_EN to trap
// misaligned half/word accesses instead of ignoring the low address bits.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DBITS       = 32,
  parameter int REGNOBITS   = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           in_memop,
  input  logic [DBITS-1:0]     in_result,
  input  logic [DBITS-1:0]     in_sdata,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_wr_reg,
  input  logic [DBITS-1:0]     in_pc,
  output logic                 stall_to_agex,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DBITS-1:0]     dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [DBITS-1:0]     dmem_wdata,
  input  logic [DBITS-1:0]     dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 mem_valid,
  output logic [REGNOBITS-1:0] mem_rd,
  output logic                 mem_wr_reg,
  output logic [DBITS-1:0]     mem_result,
  output logic [DBITS-1:0]     mem_pc,
  output logic                 mem_err,
  output logic                 fwd_valid,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic [DBITS-1:0]     fwd_data,
  output state_e               dbg_state
);

  localparam int            CW       = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  // Handshake: dmem_req rises with addr/be/we/wdata registered and all of them
  // stay constant until the cycle dmem_ack is sampled high (dmem_rdata valid in
  // that same cycle); req drops on the following edge. No new request is raised
  // in the cycle req drops, so every ack maps to exactly one request.

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic [3:0]             op_q;
  logic [1:0]             off_q;
  logic [REGNOBITS-1:0]   rd_q;
  logic                   wr_q;
  logic [DBITS-1:0]       pc_q;
  logic [DBITS-1:0]       addr_q;

  logic [3:0]             al_op;
  logic [1:0]             al_off;
  logic [3:0]             al_be;
  logic [DBITS-1:0]       al_wdata;
  logic [DBITS-1:0]       al_ldata;
  logic                   al_misaligned;
  logic                   in_is_mem;
  logic                   trap;
  logic                   cnt_last;

  // While BUSY the aligner works on the captured op so execute may change freely.
  assign al_op     = (state == BUSY) ? op_q  : in_memop;
  assign al_off    = (state == BUSY) ? off_q : in_result[1:0];
  assign in_is_mem = is_mem(in_memop);
  assign cnt_last  = (cnt == CNT_LAST);

  mem_align #(.DBITS(DBITS)) u_align (
    .op         (al_op),
    .offset     (al_off),
    .sdata      (in_sdata),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_misaligned)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = in_is_mem & al_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = al_misaligned;
  assign trap = 1'b0;
`endif

  assign stall_to_agex = (state == BUSY) & ~dmem_ack & ~cnt_last;
  assign fwd_valid     = mem_valid & mem_wr_reg;
  assign fwd_rd        = mem_rd;
  assign fwd_data      = mem_result;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= OP_NONE;
      off_q      <= 2'b00;
      rd_q       <= '0;
      wr_q       <= 1'b0;
      pc_q       <= '0;
      addr_q     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      mem_valid  <= 1'b0;
      mem_rd     <= '0;
      mem_wr_reg <= 1'b0;
      mem_result <= '0;
      mem_pc     <= '0;
      mem_err    <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_is_mem || trap) begin
              mem_valid  <= 1'b1;
              mem_rd     <= in_rd;
              mem_wr_reg <= in_wr_reg & ~trap;
              mem_result <= in_result;
              mem_pc     <= in_pc;
              mem_err    <= trap;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store(in_memop);
              dmem_addr  <= {in_result[DBITS-1:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= al_wdata;
              op_q       <= in_memop;
              off_q      <= in_result[1:0];
              rd_q       <= in_rd;
              wr_q       <= in_wr_reg;
              pc_q       <= in_pc;
              addr_q     <= in_result;
              cnt        <= '0;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack || cnt_last) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state     <= IDLE;
            mem_valid <= 1'b1;
            mem_rd    <= rd_q;
            mem_pc    <= pc_q;
            if (dmem_ack) begin
              mem_err    <= 1'b0;
              mem_wr_reg <= wr_q & ~is_store(op_q);
              mem_result <= is_store(op_q) ? addr_q : al_ldata;
            end else begin
              mem_err    <= 1'b1;
              mem_wr_reg <= 1'b0;
              mem_result <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
